// File: rtl/io_fmt_seq_if.sv
// io_fmt_seq_if: format-track, device handshake and status signals of the slow-output sequencer.
interface io_fmt_seq_if #(parameter int CNT_W = 8);
    logic             T0, SLOW_OUT, START, SIGN, DEV_ACK;
    logic [2:0]       FMT;
    logic [3:0]       MZ_NIB;
    logic             FMT_ADV, DIGIT_OF, WAIT_OF, CR_TAB_OF, CHAR_STB, BUSY, DONE, RELOAD, TIMEOUT;
    logic [4:0]       CHAR;
    logic [CNT_W-1:0] CHAR_CNT;
    modport master (
        output T0, SLOW_OUT, START, FMT, MZ_NIB, SIGN, DEV_ACK,
        input  FMT_ADV, DIGIT_OF, WAIT_OF, CR_TAB_OF, CHAR, CHAR_STB, BUSY, DONE, RELOAD, TIMEOUT, CHAR_CNT
    );
    modport slave (
        input  T0, SLOW_OUT, START, FMT, MZ_NIB, SIGN, DEV_ACK,
        output FMT_ADV, DIGIT_OF, WAIT_OF, CR_TAB_OF, CHAR, CHAR_STB, BUSY, DONE, RELOAD, TIMEOUT, CHAR_CNT
    );
endinterface

// File: rtl/io_fmt_seq.sv
// io_fmt_seq: G-15 slow-output format sequencer feeding I/O 11 format controls and a strobe/ack device.
// Define IO_FMT_TIMEOUT_EN to add the EMIT device timeout (ACK_TIMEOUT cycles).
module io_fmt_seq #(
    parameter int ACK_TIMEOUT = 4096,
    parameter int CNT_W = 8
) (
    input logic CLOCK,
    input logic rst,
    io_fmt_seq_if.slave b
);
    typedef enum logic [2:0] {IDLE, FETCH, PREC, EMIT, ADV, FIN} state_t;
    localparam logic [2:0] F_DIG = 3'd0, F_END = 3'd1, F_CR = 3'd2, F_PER = 3'd3;
    localparam logic [2:0] F_SGN = 3'd4, F_RLD = 3'd5, F_TAB = 3'd6, F_WAIT = 3'd7;
    state_t state, state_n;
    logic [2:0] code, code_n;
    logic dof, dof_n, wof, wof_n, ctof, ctof_n, stb, stb_n;
    logic busy, busy_n, done, done_n, rld, rld_n;
    logic [4:0] chr, chr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic go, timeout_hit;
    function automatic logic [4:0] enc(input logic [2:0] c, input logic s);
        return c == F_CR ? 5'b00010 : c == F_TAB ? 5'b00011 : c == F_PER ? 5'b00100 :
               c == F_RLD ? 5'b00101 : {4'b0000, s};
    endfunction
    assign go = state == IDLE && b.START && b.SLOW_OUT;
    always_comb begin
        state_n = state;
        code_n = code;
        dof_n = dof;
        wof_n = wof;
        ctof_n = ctof;
        chr_n = chr;
        stb_n = stb;
        busy_n = busy;
        cnt_n = cnt;
        done_n = 1'b0;
        rld_n = 1'b0;
        if (state != IDLE && !b.SLOW_OUT) begin
            state_n = IDLE;
            {dof_n, wof_n, ctof_n, stb_n, busy_n} = '0;
            chr_n = '0;
        end else begin
            unique case (state)
                IDLE: if (go) begin
                    state_n = FETCH;
                    cnt_n = '0;
                    busy_n = 1'b1;
                end
                FETCH: if (b.T0) begin
                    code_n = b.FMT;
                    if (b.FMT == F_END) state_n = FIN;
                    else if (b.FMT == F_SGN || b.FMT == F_PER || b.FMT == F_RLD) begin
                        chr_n = enc(b.FMT, b.SIGN);
                        stb_n = 1'b1;
                        state_n = EMIT;
                    end else begin
                        dof_n = b.FMT == F_DIG;
                        wof_n = b.FMT == F_WAIT;
                        ctof_n = b.FMT == F_CR || b.FMT == F_TAB;
                        state_n = PREC;
                    end
                end
                // The *_OF level spans exactly one word time: FETCH T0 to PREC T0.
                PREC: if (b.T0) begin
                    {dof_n, wof_n, ctof_n} = '0;
                    if (code == F_WAIT) state_n = ADV;
                    else begin
                        chr_n = code == F_DIG ? {1'b1, b.MZ_NIB} : enc(code, b.SIGN);
                        stb_n = 1'b1;
                        state_n = EMIT;
                    end
                end
                EMIT: if (b.DEV_ACK) begin
                    stb_n = 1'b0;
                    cnt_n = cnt + CNT_W'(~&cnt);
                    rld_n = code == F_RLD;
                    state_n = code == F_RLD ? FIN : ADV;
                end else if (timeout_hit) begin
                    stb_n = 1'b0;
                    state_n = FIN;
                end
                ADV: state_n = FETCH;
                FIN: begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state <= IDLE;
            code <= '0;
            {dof, wof, ctof, stb, busy, done, rld} <= '0;
            chr <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            code <= code_n;
            {dof, wof, ctof, stb, busy, done, rld} <= {dof_n, wof_n, ctof_n, stb_n, busy_n, done_n, rld_n};
            chr <= chr_n;
            cnt <= cnt_n;
        end
    end
`ifdef IO_FMT_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic tmo;
    assign timeout_hit = tcnt == TW'(ACK_TIMEOUT - 1);
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            tcnt <= '0;
            tmo <= 1'b0;
        end else begin
            tcnt <= state == EMIT ? tcnt + TW'(1) : '0;
            tmo <= go ? 1'b0 : tmo | (state == EMIT && state_n == FIN && !b.DEV_ACK);
        end
    end
    assign b.TIMEOUT = tmo;
`else
    assign timeout_hit = 1'b0 & (ACK_TIMEOUT > 0);
    assign b.TIMEOUT = 1'b0;
`endif
    assign b.FMT_ADV = state == ADV;
    assign b.DIGIT_OF = dof;
    assign b.WAIT_OF = wof;
    assign b.CR_TAB_OF = ctof;
    assign b.CHAR = chr;
    assign b.CHAR_STB = stb;
    assign b.BUSY = busy;
    assign b.DONE = done;
    assign b.RELOAD = rld;
    assign b.CHAR_CNT = cnt;
endmodule

// File: tb/tb_io_fmt_seq.sv
// tb_io_fmt_seq: table-driven, hand-written and randomized checks of io_fmt_seq against a character-stream model.
module tb_io_fmt_seq;
    localparam int WT = 8;
    localparam logic [2:0] DIG = 3'd0, FEND = 3'd1, CR = 3'd2, PER = 3'd3;
    localparam logic [2:0] SGN = 3'd4, RLD = 3'd5, TAB = 3'd6, WAT = 3'd7;
    logic CLOCK = 1'b0;
    logic rst = 1'b0;
    io_fmt_seq_if #(.CNT_W(8)) b();
    io_fmt_seq #(.ACK_TIMEOUT(16), .CNT_W(8)) dut (.CLOCK(CLOCK), .rst(rst), .b(b));
    always #5 CLOCK = ~CLOCK;

    logic [2:0] prog [16];
    logic [3:0] nibs [16];
    logic       sgns [16];
    int ptr = 0, ack_delay = 0, ack_wait = 0, phase = 0;
    int n_done, n_rld, n_adv, dof_c, wof_c, ctof_c, stb_c, multi, cyc, rld_cyc, done_cyc;
    logic [4:0] got [$];
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [2:0] c0, c1, c2;
        logic s;
        logic [3:0] n;
        int ack, nch;
        logic [4:0] e0, e1;
        int adv, rld, dofc, wofc, ctofc;
    } vec_t;
    vec_t vt [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Format track, word-time pulses and the slow device.
    initial begin
        b.T0 = 0; b.FMT = 0; b.MZ_NIB = 0; b.SIGN = 0; b.DEV_ACK = 0;
        forever begin
            @(posedge CLOCK); #1;
            if (b.FMT_ADV === 1'b1 && ptr < 15) ptr++;
            b.FMT = prog[ptr]; b.MZ_NIB = nibs[ptr]; b.SIGN = sgns[ptr];
            phase = (phase + 1) % WT;
            b.T0 = phase == 0;
            if (b.CHAR_STB !== 1'b1) begin
                b.DEV_ACK = 0;
                ack_wait = 0;
            end else if (!b.DEV_ACK) begin
                if (ack_wait >= ack_delay) b.DEV_ACK = 1;
                else ack_wait++;
            end
        end
    end

    initial forever begin
        @(negedge CLOCK);
        cyc++;
        if (b.DONE === 1'b1) begin n_done++; done_cyc = cyc; end
        if (b.RELOAD === 1'b1) begin n_rld++; rld_cyc = cyc; end
        if (b.FMT_ADV === 1'b1) n_adv++;
        if (b.DIGIT_OF === 1'b1) dof_c++;
        if (b.WAIT_OF === 1'b1) wof_c++;
        if (b.CR_TAB_OF === 1'b1) ctof_c++;
        if (b.CHAR_STB === 1'b1) stb_c++;
        if (b.CHAR_STB === 1'b1 && b.DEV_ACK) got.push_back(b.CHAR);
        if (int'(b.DIGIT_OF === 1'b1) + int'(b.WAIT_OF === 1'b1) + int'(b.CR_TAB_OF === 1'b1) > 1) multi++;
    end

    task automatic clr_mon();
        {n_done, n_rld, n_adv, dof_c, wof_c, ctof_c, stb_c} = '0;
        rld_cyc = 0; done_cyc = 0;
        got.delete();
    endtask

    task automatic clr_prog();
        for (int i = 0; i < 16; i++) begin prog[i] = FEND; nibs[i] = 0; sgns[i] = 0; end
        ptr = 0;
    endtask

    task automatic start_seq();
        clr_mon();
        @(posedge CLOCK); #1;
        b.SLOW_OUT = 1; b.START = 1;
        @(posedge CLOCK); #1;
        b.START = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) @(negedge CLOCK);
        repeat (2) @(negedge CLOCK);
        chk("done_once", n_done, 1);
        chk("busy_after", b.BUSY, 0);
    endtask

    logic [4:0] exp_q [$];
    int ns, nd, nw, nc;
    logic [2:0] c, term;
    logic [2:0] pick [6];

    initial begin
        b.START = 0; b.SLOW_OUT = 1;
        clr_prog();
        vt[0] = '{SGN, DIG, FEND, 1, 4'h7, 3, 2, 5'b00001, 5'b10111, 2, 0, WT, 0, 0};
        vt[1] = '{WAT, CR, FEND, 0, 4'h0, 2, 1, 5'b00010, 5'b00000, 2, 0, 0, WT, WT};
        vt[2] = '{RLD, FEND, FEND, 0, 4'h0, 1, 1, 5'b00101, 5'b00000, 0, 1, 0, 0, 0};
        vt[3] = '{PER, TAB, FEND, 0, 4'h0, 0, 2, 5'b00100, 5'b00011, 2, 0, 0, 0, WT};
        vt[4] = '{SGN, DIG, FEND, 0, 4'hF, 0, 2, 5'b00000, 5'b11111, 2, 0, WT, 0, 0};
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("rst_ctl", {b.DIGIT_OF, b.WAIT_OF, b.CR_TAB_OF, b.CHAR_STB, b.BUSY, b.DONE, b.RELOAD, b.FMT_ADV}, 0);
        chk("rst_char", b.CHAR, 0);
        chk("rst_cnt", b.CHAR_CNT, 0);
        chk("rst_tmo", b.TIMEOUT, 0);
        @(posedge CLOCK); #1 rst = 1;

        for (int v = 0; v < 5; v++) begin
            clr_prog();
            prog[0] = vt[v].c0; prog[1] = vt[v].c1; prog[2] = vt[v].c2;
            for (int k = 0; k < 3; k++) begin nibs[k] = vt[v].n; sgns[k] = vt[v].s; end
            ack_delay = vt[v].ack;
            start_seq();
            wait_done(1000);
            chk("vec_nchar", got.size(), vt[v].nch);
            chk("vec_char0", got.size() > 0 ? got[0] : 5'h1F, vt[v].e0);
            if (vt[v].nch > 1) chk("vec_char1", got.size() > 1 ? got[1] : 5'h1F, vt[v].e1);
            chk("vec_cnt", b.CHAR_CNT, vt[v].nch);
            chk("vec_adv", n_adv, vt[v].adv);
            chk("vec_reload", n_rld, vt[v].rld);
            if (vt[v].rld != 0) chk("reload_then_done", done_cyc - rld_cyc, 1);
            chk("vec_digit_of", dof_c, vt[v].dofc);
            chk("vec_wait_of", wof_c, vt[v].wofc);
            chk("vec_crtab_of", ctof_c, vt[v].ctofc);
        end

        // Reset while a character is being strobed.
        clr_prog();
        prog[0] = SGN; sgns[0] = 1;
        ack_delay = 1000;
        start_seq();
        for (int i = 0; i < 100 && b.CHAR_STB !== 1'b1; i++) @(negedge CLOCK);
        chk("emit_reached", b.CHAR_STB, 1);
        @(posedge CLOCK); #1 rst = 0;
        @(posedge CLOCK); #1 rst = 1;
        @(negedge CLOCK);
        chk("rst_emit_stb", b.CHAR_STB, 0);
        chk("rst_emit_busy", b.BUSY, 0);
        chk("rst_emit_cnt", b.CHAR_CNT, 0);
        repeat (20) @(negedge CLOCK);
        chk("rst_emit_idle", {b.BUSY, b.CHAR_STB, b.DONE}, 0);

        // START while busy is ignored; SLOW_OUT drop in digit PREC aborts.
        clr_prog();
        prog[0] = SGN; prog[1] = DIG; sgns[0] = 1; nibs[1] = 4'h9;
        ack_delay = 3;
        start_seq();
        for (int i = 0; i < 200 && b.CHAR_CNT != 1; i++) @(negedge CLOCK);
        @(posedge CLOCK); #1 b.START = 1;
        @(posedge CLOCK); #1 b.START = 0;
        for (int i = 0; i < 200 && b.DIGIT_OF !== 1'b1; i++) @(negedge CLOCK);
        chk("abort_digit_of_up", b.DIGIT_OF, 1);
        chk("start_ignored_cnt", b.CHAR_CNT, 1);
        chk("start_ignored_adv", n_adv, 1);
        @(posedge CLOCK); #1 b.SLOW_OUT = 0;
        @(posedge CLOCK); #1 b.SLOW_OUT = 1;
        @(negedge CLOCK);
        chk("abort_digit_of", b.DIGIT_OF, 0);
        chk("abort_busy", b.BUSY, 0);
        repeat (30) @(negedge CLOCK);
        chk("abort_no_done", n_done, 0);
        chk("abort_no_reload", n_rld, 0);
        chk("abort_cnt_kept", b.CHAR_CNT, 1);
        chk("abort_chars", got.size(), 1);

`ifdef IO_FMT_TIMEOUT_EN
        clr_prog();
        prog[0] = SGN;
        ack_delay = 1000;
        start_seq();
        wait_done(300);
        chk("tmo_emit_cycles", stb_c, 16);
        chk("tmo_flag", b.TIMEOUT, 1);
        chk("tmo_cnt", b.CHAR_CNT, 0);
        chk("tmo_nchar", got.size(), 0);
        clr_prog();
        start_seq();
        @(negedge CLOCK);
        chk("tmo_cleared", b.TIMEOUT, 0);
        wait_done(300);
`endif

        // Randomized programs against the character-stream model.
        pick[0] = DIG; pick[1] = CR; pick[2] = PER; pick[3] = SGN; pick[4] = TAB; pick[5] = WAT;
        for (int it = 0; it < 20; it++) begin
            clr_prog();
            exp_q.delete();
            ns = $urandom_range(1, 5);
            nd = 0; nw = 0; nc = 0;
            for (int k = 0; k < ns; k++) begin
                c = pick[$urandom_range(0, 5)];
                prog[k] = c;
                nibs[k] = 4'($urandom);
                sgns[k] = 1'($urandom);
                if (c == DIG) begin nd++; exp_q.push_back({1'b1, nibs[k]}); end
                else if (c == SGN) exp_q.push_back({4'b0000, sgns[k]});
                else if (c == CR) begin nc++; exp_q.push_back(5'd2); end
                else if (c == TAB) begin nc++; exp_q.push_back(5'd3); end
                else if (c == PER) exp_q.push_back(5'd4);
                else nw++;
            end
            term = $urandom_range(0, 1) != 0 ? RLD : FEND;
            prog[ns] = term;
            if (term == RLD) exp_q.push_back(5'd5);
            ack_delay = $urandom_range(0, 4);
            start_seq();
            wait_done(2000);
            chk("rnd_nchar", got.size(), exp_q.size());
            for (int k = 0; k < exp_q.size(); k++) chk("rnd_char", k < got.size() ? got[k] : 5'h1F, exp_q[k]);
            chk("rnd_cnt", b.CHAR_CNT, exp_q.size());
            chk("rnd_adv", n_adv, ns);
            chk("rnd_reload", n_rld, int'(term == RLD));
            chk("rnd_of_time", dof_c + wof_c + ctof_c, WT * (nd + nw + nc));
        end

        chk("one_hot_of", multi, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
